// File: rtl/axis_packetizer.sv
// axis_packetizer: frames a continuous AXI-Stream word source into packets.
// A one-word hold register (H) keeps the newest beat back until it is known
// whether it closes the packet (length reached or the input went idle), and
// an output register (O) drives the master port directly.
module axis_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [TMO_WIDTH-1:0]  cfg_timeout,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  idle,
  output logic                  pkt_done,
  output logic                  pkt_timeout
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0] TMO_ZERO = {TMO_WIDTH{1'b0}};
  localparam logic [TMO_WIDTH-1:0] TMO_MAX  = {TMO_WIDTH{1'b1}};

  // Hold register H
  logic [DATA_WIDTH-1:0] h_data_r;
  logic                  h_valid_r;

  // Output register O
  logic [DATA_WIDTH-1:0] o_data_r;
  logic                  o_last_r;
  logic                  o_valid_r;

  // Beat counter and idle timer
  logic [LEN_WIDTH-1:0]  cnt_r;
  logic [TMO_WIDTH-1:0]  timer_r;

  // Registered status pulses
  logic                  pkt_done_r;
  logic                  pkt_timeout_r;

  // Combinational decode
  logic                  o_free_s;
  logic [LEN_WIDTH-1:0]  len_m1_s;
  logic                  h_final_s;
  logic                  tmo_en_s;
  logic [TMO_WIDTH-1:0]  tmo_m1_s;
  logic                  tmo_hit_s;
  logic                  close_s;
  logic                  h_move_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  m_last_hs_s;
  logic [LEN_WIDTH-1:0]  cnt_nxt_s;
  logic [TMO_WIDTH-1:0]  timer_nxt_s;

  // Decode the move/close conditions from the current register state.
  // Length arithmetic wraps modulo 2**LEN_WIDTH so a length of 0 means a
  // full 2**LEN_WIDTH-beat packet.
  always_comb begin
    o_free_s    = !o_valid_r || m_axis_tready;
    len_m1_s    = cfg_pkt_len - LEN_ONE;
    h_final_s   = (cnt_r == len_m1_s);
    tmo_en_s    = (cfg_timeout != TMO_ZERO);
    tmo_m1_s    = cfg_timeout - TMO_ONE;
    // A new input word always wins over an expiring timer.
    tmo_hit_s   = tmo_en_s && h_valid_r && !s_axis_tvalid && (timer_r >= tmo_m1_s);
    close_s     = h_final_s || tmo_hit_s;
    h_move_s    = h_valid_r && o_free_s && (h_final_s || s_axis_tvalid || tmo_hit_s);
    in_ready_s  = !areset && (!h_valid_r || h_move_s);
    accept_s    = s_axis_tvalid && in_ready_s;
    m_last_hs_s = o_valid_r && m_axis_tready && o_last_r;
  end

  // Next beat count: restart after a packet closes, advance on other moves.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (h_move_s) begin
      if (close_s) begin
        cnt_nxt_s = LEN_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + LEN_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Next idle-timer value: clear on any traffic, otherwise count up while a
  // word waits in H, saturating so it never wraps back below the threshold.
  always_comb begin
    timer_nxt_s = timer_r;
    if (accept_s || h_move_s) begin
      timer_nxt_s = TMO_ZERO;
    end else if (h_valid_r && (timer_r != TMO_MAX)) begin
      timer_nxt_s = timer_r + TMO_ONE;
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // Hold register: load on input handshake, empty when its word moves to O.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      h_data_r  <= {DATA_WIDTH{1'b0}};
      h_valid_r <= 1'b0;
    end else if (accept_s) begin
      h_data_r  <= s_axis_tdata;
      h_valid_r <= 1'b1;
    end else if (h_move_s) begin
      h_valid_r <= 1'b0;
    end
  end

  // Output register: take the held word, or drain once the consumer took it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      o_data_r  <= {DATA_WIDTH{1'b0}};
      o_last_r  <= 1'b0;
      o_valid_r <= 1'b0;
    end else if (h_move_s) begin
      o_data_r  <= h_data_r;
      o_last_r  <= close_s;
      o_valid_r <= 1'b1;
    end else if (o_free_s) begin
      o_valid_r <= 1'b0;
    end
  end

  // Beat counter of the packet currently being framed.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_r <= LEN_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Idle timer for the word sitting in H.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      timer_r <= TMO_ZERO;
    end else begin
      timer_r <= timer_nxt_s;
    end
  end

  // Status pulses: packet delivered downstream, packet closed by idle timeout.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_done_r    <= 1'b0;
      pkt_timeout_r <= 1'b0;
    end else begin
      pkt_done_r    <= m_last_hs_s;
      pkt_timeout_r <= h_move_s && tmo_hit_s && !h_final_s;
    end
  end

  assign s_axis_tready = in_ready_s;
  assign m_axis_tdata  = o_data_r;
  assign m_axis_tlast  = o_last_r;
  assign m_axis_tvalid = o_valid_r;
  assign idle          = !h_valid_r && !o_valid_r && (cnt_r == LEN_ZERO);
  assign pkt_done      = pkt_done_r;
  assign pkt_timeout   = pkt_timeout_r;

endmodule
